// File: rtl/brightness_gain_pipe.sv
// Two-stage Avalon-ST brightness/gain stage: S1 multiplies each channel by a frame-locked gain,
// S2 rounds, saturates and optionally inverts into the output registers.
module brightness_gain_pipe #(
    parameter int CH_W   = 4,
    parameter int N_CH   = 3,
    parameter int GAIN_W = 4,
    parameter int FRAC_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [GAIN_W-1:0]      gain,
    input  logic [1:0]             mode,
    input  logic [N_CH*CH_W-1:0]   data_in,
    input  logic                   sop_in,
    input  logic                   eop_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    output logic [N_CH*CH_W-1:0]   data_out,
    output logic                   sop_out,
    output logic                   eop_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [CNT_W-1:0]       frame_cnt
);

    localparam int P_W  = CH_W + GAIN_W;
    // One spare bit so the rounding add can never wrap, whatever the parameters.
    localparam int R_W  = P_W + 1;
    localparam int HALF = (FRAC_W > 0) ? (1 << ((FRAC_W > 0) ? (FRAC_W - 1) : 0)) : 0;
    localparam logic [CH_W-1:0]   CH_MAX     = '1;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1) << FRAC_W;

    localparam logic [1:0] MODE_BYPASS   = 2'b00;
    localparam logic [1:0] MODE_GAIN     = 2'b01;
    localparam logic [1:0] MODE_INV      = 2'b10;
    localparam logic [1:0] MODE_GAIN_INV = 2'b11;

    logic                  en;
    logic                  sink_fire;
    logic                  src_fire;
    logic [GAIN_W-1:0]     gain_reg;
    logic [1:0]            mode_reg;
    logic [GAIN_W-1:0]     gain_eff;
    logic [1:0]            mode_eff;

    logic                  s1_valid_reg;
    logic                  s1_sop_reg;
    logic                  s1_eop_reg;
    logic [1:0]            s1_mode_reg;
    logic [N_CH*CH_W-1:0]  s1_pix_reg;
    logic [P_W-1:0]        prod_next [N_CH];
    logic [P_W-1:0]        s1_prod_reg [N_CH];

    logic [N_CH*CH_W-1:0]  pix_next;
    logic [N_CH*CH_W-1:0]  data_out_reg;
    logic                  sop_out_reg;
    logic                  eop_out_reg;
    logic                  valid_out_reg;
    logic [CNT_W-1:0]      frame_cnt_reg;

    assign en        = ready_in || !valid_out_reg;
    assign ready_out = en;
    assign sink_fire = valid_in && en;
    assign src_fire  = valid_out_reg && ready_in;

    // The SOP beat itself already uses the newly requested gain and mode.
    assign gain_eff = sop_in ? gain : gain_reg;
    assign mode_eff = sop_in ? mode : mode_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CH_W-1:0] ch_in;
            logic [CH_W-1:0] ch_raw;
            logic [R_W-1:0]  ch_rnd;
            logic [CH_W-1:0] ch_sat;
            logic [CH_W-1:0] ch_pick;

            assign ch_in         = data_in[gi*CH_W +: CH_W];
            assign prod_next[gi] = P_W'(ch_in) * P_W'(gain_eff);

            assign ch_raw = s1_pix_reg[gi*CH_W +: CH_W];
            assign ch_rnd = (R_W'(s1_prod_reg[gi]) + R_W'(HALF)) >> FRAC_W;
            assign ch_sat = (ch_rnd > R_W'(CH_MAX)) ? CH_MAX : ch_rnd[CH_W-1:0];

            always_comb begin
                ch_pick = ch_raw;
                case (s1_mode_reg)
                    MODE_BYPASS:   ch_pick = ch_raw;
                    MODE_GAIN:     ch_pick = ch_sat;
                    MODE_INV:      ch_pick = CH_MAX - ch_raw;
                    MODE_GAIN_INV: ch_pick = CH_MAX - ch_sat;
                    default:       ch_pick = ch_raw;
                endcase
            end

            assign pix_next[gi*CH_W +: CH_W] = ch_pick;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            gain_reg      <= GAIN_UNITY;
            mode_reg      <= MODE_BYPASS;
            s1_valid_reg  <= 1'b0;
            s1_sop_reg    <= 1'b0;
            s1_eop_reg    <= 1'b0;
            s1_mode_reg   <= MODE_BYPASS;
            s1_pix_reg    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                s1_prod_reg[i] <= '0;
            end
            data_out_reg  <= '0;
            sop_out_reg   <= 1'b0;
            eop_out_reg   <= 1'b0;
            valid_out_reg <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            if (sink_fire && sop_in) begin
                gain_reg <= gain;
                mode_reg <= mode;
            end
            // Both stages advance together or hold together, so the output obeys the hold rule.
            if (en) begin
                s1_valid_reg  <= valid_in;
                s1_sop_reg    <= sop_in;
                s1_eop_reg    <= eop_in;
                s1_mode_reg   <= mode_eff;
                s1_pix_reg    <= data_in;
                for (int i = 0; i < N_CH; i++) begin
                    s1_prod_reg[i] <= prod_next[i];
                end
                data_out_reg  <= pix_next;
                sop_out_reg   <= s1_sop_reg;
                eop_out_reg   <= s1_eop_reg;
                valid_out_reg <= s1_valid_reg;
            end
            if (src_fire && eop_out_reg) begin
                frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign data_out  = data_out_reg;
    assign sop_out   = sop_out_reg;
    assign eop_out   = eop_out_reg;
    assign valid_out = valid_out_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_brightness_gain_pipe.sv
// Bench for brightness_gain_pipe: directed vectors plus a randomized stream scored against
// a per-pixel arithmetic model and an expected-beat queue.
`timescale 1ns/1ps
module tb_brightness_gain_pipe;

    localparam int CH_W = 4;
    localparam int N_CH = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  gain = '0;
    logic [1:0]  mode = '0;
    logic [11:0] data_in = '0;
    logic        sop_in = 1'b0;
    logic        eop_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b1;
    logic        ready_out;
    logic [11:0] data_out;
    logic        sop_out;
    logic        eop_out;
    logic        valid_out;
    logic [15:0] frame_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [13:0] exp_q [$];
    logic [3:0]  m_gain = 4'd4;
    logic [1:0]  m_mode = 2'b00;
    logic [15:0] m_cnt = '0;
    logic        accepted = 1'b0;
    int          delivered = 0;

    always #5 clk = ~clk;

    brightness_gain_pipe #(
        .CH_W(4), .N_CH(3), .GAIN_W(4), .FRAC_W(2), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .gain(gain), .mode(mode),
        .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in), .valid_in(valid_in),
        .ready_out(ready_out), .data_out(data_out), .sop_out(sop_out), .eop_out(eop_out),
        .valid_out(valid_out), .ready_in(ready_in), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Per channel: scale by gain/4 rounding half up, clamp to 15, then optionally invert.
    function automatic logic [11:0] ref_pix(input logic [11:0] pix, input logic [3:0] g,
                                            input logic [1:0] m);
        logic [11:0] res;
        int v;
        int s;
        res = '0;
        for (int c = 0; c < N_CH; c++) begin
            v = int'(pix[c*CH_W +: CH_W]);
            s = (v * int'(g) + 2) / 4;
            if (s > 15) s = 15;
            case (m)
                2'b00:   res[c*CH_W +: CH_W] = 4'(v);
                2'b01:   res[c*CH_W +: CH_W] = 4'(s);
                2'b10:   res[c*CH_W +: CH_W] = 4'(15 - v);
                default: res[c*CH_W +: CH_W] = 4'(15 - s);
            endcase
        end
        return res;
    endfunction

    task automatic cycle(input logic v, input logic s, input logic e, input logic [11:0] d,
                         input logic [3:0] g, input logic [1:0] m, input logic rdy,
                         input logic rst_n);
        logic [13:0] front;
        logic        hold_pend;
        logic [13:0] hold_val;
        valid_in = v; sop_in = s; eop_in = e; data_in = d;
        gain = g; mode = m; ready_in = rdy; reset = rst_n;
        #2;
        accepted  = 1'b0;
        hold_pend = 1'b0;
        hold_val  = {sop_out, eop_out, data_out};
        if (rst_n) begin
            chk("ready_out", {31'd0, ready_out}, {31'd0, rdy || !valid_out});
            if (valid_out && rdy) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", {31'd0, valid_out}, 32'd0);
                end else begin
                    front = exp_q.pop_front();
                    chk("data_out", {20'd0, data_out}, {20'd0, front[11:0]});
                    chk("sop_out", {31'd0, sop_out}, {31'd0, front[13]});
                    chk("eop_out", {31'd0, eop_out}, {31'd0, front[12]});
                    if (front[12]) m_cnt = m_cnt + 16'd1;
                    delivered++;
                end
            end
            if (v && ready_out) begin
                accepted = 1'b1;
                if (s) begin
                    m_gain = g;
                    m_mode = m;
                end
                exp_q.push_back({s, e, ref_pix(d, m_gain, m_mode)});
            end
            hold_pend = valid_out && !rdy;
        end else begin
            exp_q.delete();
            m_gain = 4'd4;
            m_mode = 2'b00;
            m_cnt  = '0;
        end
        @(posedge clk);
        #1;
        chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
        if (hold_pend) begin
            chk("hold_valid", {31'd0, valid_out}, 32'd1);
            chk("hold_beat", {18'd0, sop_out, eop_out, data_out}, {18'd0, hold_val});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 12'h000, 4'd0, 2'b00, 1'b1, 1'b1);
        end
        chk("drain_pending", exp_q.size(), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 12'h000, 4'd0, 2'b00, 1'b1, 1'b1);
    endtask

    // Single beat into an empty pipe: invisible after one edge, on the output after two.
    task automatic one_beat(input string tag, input logic [11:0] d, input logic [3:0] g,
                            input logic [1:0] m, input logic s, input logic e,
                            input logic [11:0] expv);
        drain();
        cycle(1'b1, s, e, d, g, m, 1'b1, 1'b1);
        chk({tag, "_lat1"}, {31'd0, valid_out}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 12'h000, 4'd0, 2'b00, 1'b0, 1'b1);
        chk({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
        chk({tag, "_data"}, {20'd0, data_out}, {20'd0, expv});
    endtask

    initial begin
        logic [11:0] bp_data [8];
        logic [15:0] base_cnt;
        int          idx;
        int          base_del;

        cycle(1'b0, 1'b0, 1'b0, 12'h000, 4'd0, 2'b00, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 12'hFFF, 4'd15, 2'b01, 1'b1, 1'b0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_data", {20'd0, data_out}, 32'd0);
        chk("rst_sop_eop", {30'd0, sop_out, eop_out}, 32'd0);
        chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);

        one_beat("pre_sop", 12'h7C4, 4'd8, 2'b01, 1'b0, 1'b0, 12'h7C4);
        one_beat("round", 12'hA53, 4'b0110, 2'b01, 1'b1, 1'b1, 12'hF85);
        one_beat("sat", 12'h888, 4'b1111, 2'b01, 1'b1, 1'b1, 12'hFFF);
        one_beat("unity", 12'h3C7, 4'b0100, 2'b01, 1'b1, 1'b1, 12'h3C7);
        one_beat("inv", 12'h0F5, 4'b0000, 2'b10, 1'b1, 1'b1, 12'hF0A);
        one_beat("gain_inv", 12'h312, 4'b1000, 2'b11, 1'b1, 1'b1, 12'h9DB);
        one_beat("zero_gain", 12'hABC, 4'd0, 2'b01, 1'b1, 1'b1, 12'h000);
        one_beat("zero_gain_inv", 12'hABC, 4'd0, 2'b11, 1'b1, 1'b1, 12'hFFF);

        drain();
        base_cnt = m_cnt;
        one_beat("lock_sop", 12'h111, 4'd4, 2'b01, 1'b1, 1'b0, 12'h111);
        one_beat("lock_mid", 12'h111, 4'd8, 2'b01, 1'b0, 1'b0, 12'h111);
        one_beat("lock_eop", 12'h111, 4'd8, 2'b11, 1'b0, 1'b1, 12'h111);
        one_beat("lock_next", 12'h111, 4'd8, 2'b01, 1'b1, 1'b1, 12'h222);
        drain();
        chk("lock_frames", {16'd0, frame_cnt}, {16'd0, base_cnt + 16'd2});

        for (int i = 0; i < 8; i++) bp_data[i] = 12'($urandom);
        base_del = delivered;
        idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
            cycle(1'b1, idx == 0, idx == 7, bp_data[idx], 4'd6, 2'b01,
                  !(cyc >= 4 && cyc < 7), 1'b1);
            if (cyc >= 4 && cyc < 7) chk("bp_ready_low", {31'd0, ready_out}, 32'd0);
            if (accepted) idx++;
        end
        chk("bp_accepted", idx, 32'd8);
        drain();
        chk("bp_delivered", delivered - base_del, 32'd8);

        cycle(1'b1, 1'b1, 1'b0, 12'h123, 4'd8, 2'b01, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 12'h456, 4'd8, 2'b01, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 12'h000, 4'd0, 2'b00, 1'b0, 1'b0);
        chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
        chk("mid_rst_data", {20'd0, data_out}, 32'd0);
        chk("mid_rst_cnt", {16'd0, frame_cnt}, 32'd0);
        one_beat("post_rst", 12'h5A3, 4'd8, 2'b01, 1'b0, 1'b0, 12'h5A3);
        one_beat("post_rst_sop", 12'h111, 4'd8, 2'b01, 1'b1, 1'b1, 12'h222);

        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, 12'($urandom), 4'($urandom), 2'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
